// File: rtl/i2c_txn_sched_pkg.sv
// i2c_txn_sched_pkg
// Shared definitions for the ADT7420 transaction scheduler: FSM state
// encoding (also exported on the ILA probe), bus owner codes, the ADT7420
// address and temperature register pointer, and the byte-count encodings
// understood by the byte-level I2C master.
package i2c_txn_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } sched_state_t;

  typedef enum logic {
    OWNER_HOST = 1'b0,
    OWNER_POLL = 1'b1
  } owner_t;

  localparam logic [6:0] ADT7420_ADDR     = 7'h48;
  localparam logic [7:0] ADT7420_TEMP_REG = 8'h00;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;

  // The host may write any value into its length field; only 2 means a
  // two-byte access, everything else collapses to a single byte.
  function automatic logic [1:0] norm_len(input logic [1:0] len);
    return (len == 2'd2) ? LEN_2 : LEN_1;
  endfunction

endpackage

// File: rtl/i2c_poll_timer.sv
// i2c_poll_timer
// Free-running auto-poll interval counter with a sticky request flag.
// Only instantiated when I2C_TXN_SCHED_AUTOPOLL_EN is defined.
//
// Ports:
//   clk       in   scheduler clock
//   rst_n     in   asynchronous active-low reset
//   poll_en   in   counter runs while high, held at 0 while low
//   poll_clr  in   scheduler has finished servicing the pending poll
//   poll_pend out  a poll is owed to the scheduler
module i2c_poll_timer #(
  parameter int POLL_PERIOD = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic poll_en,
  input  logic poll_clr,
  output logic poll_pend
);

  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  logic [PW-1:0] cnt;
  logic          wrap;

  assign wrap = poll_en && (cnt == PW'(POLL_PERIOD - 1));

  // Interval counter: 0..POLL_PERIOD-1, parked at 0 while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!poll_en || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  // A wrap landing on the same cycle as a clear must win, otherwise a new
  // poll period would be silently lost. Repeated wraps coalesce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_pend <= 1'b0;
    end else if (wrap) begin
      poll_pend <= 1'b1;
    end else if (poll_clr) begin
      poll_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_txn_sched.sv
// i2c_txn_sched
// Shares one byte-level I2C master between host register accesses
// (Opal Kelly wire-in/wire-out) and an optional periodic ADT7420
// temperature poll. Sequences each command, aborts on a completion
// timeout and latches results for host readback and ILA probing.
//
// Build option: define I2C_TXN_SCHED_AUTOPOLL_EN to compile in the poll
// timer and temp/temp_valid logic; otherwise poll_en is ignored and
// temp/temp_valid read as 0.
//
// Ports:
//   FSM_Clk, rst_n                       clock, async active-low reset
//   host_req/rw/reg/wdata/len            host command, rising edge triggers
//   host_busy/done/rdata/err             host status and read data
//   poll_en                              auto-poll enable
//   temp, temp_valid                     last good temperature reading
//   m_start/rw/addr/reg/wdata/len/abort  command interface to the master
//   m_done, m_ack_err, m_rdata           completion from the master
//   state                                FSM state for ILA probe0
module i2c_txn_sched
  import i2c_txn_sched_pkg::*;
#(
  parameter int         POLL_PERIOD = 1_000_000,
  parameter int         TIMEOUT     = 100_000,
  parameter logic [6:0] DEV_ADDR    = ADT7420_ADDR
) (
  input  logic        FSM_Clk,
  input  logic        rst_n,
  input  logic        host_req,
  input  logic        host_rw,
  input  logic [7:0]  host_reg,
  input  logic [7:0]  host_wdata,
  input  logic [1:0]  host_len,
  output logic        host_busy,
  output logic        host_done,
  output logic [15:0] host_rdata,
  output logic        host_err,
  input  logic        poll_en,
  output logic [15:0] temp,
  output logic        temp_valid,
  output logic        m_start,
  output logic        m_rw,
  output logic [6:0]  m_addr,
  output logic [7:0]  m_reg,
  output logic [7:0]  m_wdata,
  output logic [1:0]  m_len,
  output logic        m_abort,
  input  logic        m_done,
  input  logic        m_ack_err,
  input  logic [15:0] m_rdata,
  output logic [7:0]  state
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  sched_state_t  cur_state;
  sched_state_t  nxt_state;
  owner_t        owner;

  logic          host_req_q;
  logic          host_edge;
  logic          host_pend;
  logic          hreq_rw;
  logic [7:0]    hreq_reg;
  logic [7:0]    hreq_wdata;
  logic [1:0]    hreq_len;

  logic [TW-1:0] to_cnt;
  logic          to_expired;

  logic          poll_pend;
  logic          poll_clr;

  assign host_edge  = host_req && !host_req_q;
  assign to_expired = (to_cnt == TW'(TIMEOUT - 1));
  assign host_busy  = host_pend || ((owner == OWNER_HOST) && (cur_state != ST_IDLE));
  assign state      = 8'(cur_state);

  // Poll service ends when the scheduler leaves WAIT on a poll transaction,
  // whichever way it leaves.
  assign poll_clr = (cur_state == ST_WAIT) && (owner == OWNER_POLL) && (m_done || to_expired);

`ifdef I2C_TXN_SCHED_AUTOPOLL_EN
  i2c_poll_timer #(
    .POLL_PERIOD (POLL_PERIOD)
  ) u_poll_timer (
    .clk       (FSM_Clk),
    .rst_n     (rst_n),
    .poll_en   (poll_en),
    .poll_clr  (poll_clr),
    .poll_pend (poll_pend)
  );

  // Temperature is captured alongside the WAIT->DONE transition so it is
  // already valid in the DONE cycle. A NACK or timeout keeps the old value
  // but marks it stale.
  always_ff @(posedge FSM_Clk or negedge rst_n) begin
    if (!rst_n) begin
      temp       <= '0;
      temp_valid <= 1'b0;
    end else if ((cur_state == ST_WAIT) && (owner == OWNER_POLL)) begin
      if (m_done) begin
        if (!m_ack_err) begin
          temp       <= m_rdata;
          temp_valid <= 1'b1;
        end else begin
          temp_valid <= 1'b0;
        end
      end else if (to_expired) begin
        temp_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_poll_cfg;

  assign poll_pend       = 1'b0;
  assign temp            = '0;
  assign temp_valid      = 1'b0;
  assign unused_poll_cfg = poll_en & (POLL_PERIOD != 0) & poll_clr;
`endif

  // State register.
  always_ff @(posedge FSM_Clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic. m_done takes priority over the timeout when both
  // happen in the same cycle; m_done is ignored outside WAIT.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_IDLE:  if (host_pend || poll_pend) nxt_state = ST_ARB;
      ST_ARB:   nxt_state = ST_ISSUE;
      ST_ISSUE: nxt_state = ST_WAIT;
      ST_WAIT: begin
        if (m_done) begin
          nxt_state = ST_DONE;
        end else if (to_expired) begin
          nxt_state = ST_ERR;
        end
      end
      ST_DONE:  nxt_state = ST_IDLE;
      ST_ERR:   nxt_state = ST_IDLE;
      default:  nxt_state = ST_IDLE;
    endcase
  end

  // Strobe outputs decoded from state.
  always_comb begin
    m_start   = 1'b0;
    m_abort   = 1'b0;
    host_done = 1'b0;
    case (cur_state)
      ST_ISSUE: m_start = 1'b1;
      ST_DONE:  host_done = (owner == OWNER_HOST);
      ST_ERR: begin
        m_abort   = 1'b1;
        host_done = (owner == OWNER_HOST);
      end
      default: ;
    endcase
  end

  // Host request capture, arbitration, command registers, timeout counter
  // and host result latching. The owner is decided when leaving IDLE so
  // host_busy is already correct during ARB; results are latched on the
  // WAIT exit edge so they are visible together with host_done.
  always_ff @(posedge FSM_Clk or negedge rst_n) begin
    if (!rst_n) begin
      host_req_q <= 1'b0;
      host_pend  <= 1'b0;
      hreq_rw    <= 1'b0;
      hreq_reg   <= '0;
      hreq_wdata <= '0;
      hreq_len   <= '0;
      owner      <= OWNER_HOST;
      m_rw       <= 1'b0;
      m_addr     <= '0;
      m_reg      <= '0;
      m_wdata    <= '0;
      m_len      <= '0;
      to_cnt     <= '0;
      host_rdata <= '0;
      host_err   <= 1'b0;
    end else begin
      host_req_q <= host_req;

      if (host_edge && !host_busy) begin
        host_pend  <= 1'b1;
        hreq_rw    <= host_rw;
        hreq_reg   <= host_reg;
        hreq_wdata <= host_wdata;
        hreq_len   <= norm_len(host_len);
        host_err   <= 1'b0;
      end

      case (cur_state)
        ST_IDLE: begin
          if (host_pend) begin
            owner <= OWNER_HOST;
          end else if (poll_pend) begin
            owner <= OWNER_POLL;
          end
        end
        ST_ARB: begin
          m_addr <= DEV_ADDR;
          if (owner == OWNER_HOST) begin
            m_rw    <= hreq_rw;
            m_reg   <= hreq_reg;
            m_wdata <= hreq_wdata;
            m_len   <= hreq_len;
          end else begin
            m_rw    <= 1'b1;
            m_reg   <= ADT7420_TEMP_REG;
            m_wdata <= '0;
            m_len   <= LEN_2;
          end
        end
        ST_ISSUE: begin
          to_cnt <= '0;
        end
        ST_WAIT: begin
          if (m_done) begin
            if (owner == OWNER_HOST) begin
              if (m_rw) begin
                host_rdata <= m_rdata;
              end
              host_err  <= m_ack_err;
              host_pend <= 1'b0;
            end
          end else if (to_expired) begin
            if (owner == OWNER_HOST) begin
              host_err  <= 1'b1;
              host_pend <= 1'b0;
            end
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_sched.sv
// tb_i2c_txn_sched
// Directed bench for i2c_txn_sched with a command scoreboard: every
// request the bench triggers pushes the command the master should see,
// and each m_start pops and compares it. The auto-poll section adapts to
// whether I2C_TXN_SCHED_AUTOPOLL_EN is defined.
module tb_i2c_txn_sched;

  localparam int POLL_PERIOD = 100;
  localparam int TIMEOUT     = 50;

  logic        FSM_Clk;
  logic        rst_n;
  logic        host_req;
  logic        host_rw;
  logic [7:0]  host_reg;
  logic [7:0]  host_wdata;
  logic [1:0]  host_len;
  logic        host_busy;
  logic        host_done;
  logic [15:0] host_rdata;
  logic        host_err;
  logic        poll_en;
  logic [15:0] temp;
  logic        temp_valid;
  logic        m_start;
  logic        m_rw;
  logic [6:0]  m_addr;
  logic [7:0]  m_reg;
  logic [7:0]  m_wdata;
  logic [1:0]  m_len;
  logic        m_abort;
  logic        m_done;
  logic        m_ack_err;
  logic [15:0] m_rdata;
  logic [7:0]  state;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] regp;
    logic [7:0] wdata;
    logic [1:0] len;
  } cmd_t;

  cmd_t cmd_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  i2c_txn_sched #(
    .POLL_PERIOD (POLL_PERIOD),
    .TIMEOUT     (TIMEOUT),
    .DEV_ADDR    (7'h48)
  ) dut (
    .FSM_Clk    (FSM_Clk),
    .rst_n      (rst_n),
    .host_req   (host_req),
    .host_rw    (host_rw),
    .host_reg   (host_reg),
    .host_wdata (host_wdata),
    .host_len   (host_len),
    .host_busy  (host_busy),
    .host_done  (host_done),
    .host_rdata (host_rdata),
    .host_err   (host_err),
    .poll_en    (poll_en),
    .temp       (temp),
    .temp_valid (temp_valid),
    .m_start    (m_start),
    .m_rw       (m_rw),
    .m_addr     (m_addr),
    .m_reg      (m_reg),
    .m_wdata    (m_wdata),
    .m_len      (m_len),
    .m_abort    (m_abort),
    .m_done     (m_done),
    .m_ack_err  (m_ack_err),
    .m_rdata    (m_rdata),
    .state      (state)
  );

  // 100 MHz scheduler clock.
  initial begin
    FSM_Clk = 1'b0;
    forever #5 FSM_Clk = ~FSM_Clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=stalled required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock; all driving and sampling happens 1 ns after posedge.
  task automatic tick();
    @(posedge FSM_Clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise host_req with the given fields and record the command the
  // master is expected to receive (len given already normalised).
  task automatic applyStimulus(input logic rw, input logic [7:0] regp, input logic [7:0] wdata,
                               input logic [1:0] len, input logic [1:0] exp_len);
    cmd_t c;
    host_rw    = rw;
    host_reg   = regp;
    host_wdata = wdata;
    host_len   = len;
    host_req   = 1'b1;
    c = '{rw: rw, addr: 7'h48, regp: regp, wdata: wdata, len: exp_len};
    cmd_q.push_back(c);
  endtask

  task automatic pushPoll();
    cmd_t c;
    c = '{rw: 1'b1, addr: 7'h48, regp: 8'h00, wdata: 8'h00, len: 2'd2};
    cmd_q.push_back(c);
  endtask

  task automatic waitStart(input string tag, input int budget, output int waited);
    waited = 0;
    while (m_start !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
    checkOutput({tag, " m_start seen"}, {31'd0, m_start}, 32'd1);
  endtask

  task automatic checkCommand(input string tag);
    cmd_t c;
    if (cmd_q.size() == 0) begin
      checkOutput({tag, " scoreboard nonempty"}, 32'd0, 32'd1);
    end else begin
      c = cmd_q.pop_front();
      checkOutput({tag, " m_rw"},   {31'd0, m_rw},   {31'd0, c.rw});
      checkOutput({tag, " m_addr"}, {25'd0, m_addr}, {25'd0, c.addr});
      checkOutput({tag, " m_reg"},  {24'd0, m_reg},  {24'd0, c.regp});
      checkOutput({tag, " m_len"},  {30'd0, m_len},  {30'd0, c.len});
      if (!c.rw) begin
        checkOutput({tag, " m_wdata"}, {24'd0, m_wdata}, {24'd0, c.wdata});
      end
    end
  endtask

  // Master model: completion pulse for one cycle with data and ack status.
  task automatic respond(input logic [15:0] data, input logic ack_err);
    m_rdata   = data;
    m_ack_err = ack_err;
    m_done    = 1'b1;
    tick();
    m_done    = 1'b0;
    m_ack_err = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " strobes/state"}, {22'd0, state, m_start, m_abort}, 32'd0);
    checkOutput({tag, " cmd fields"}, {6'd0, m_rw, m_addr, m_reg, m_wdata, m_len}, 32'd0);
    checkOutput({tag, " host outs"}, {13'd0, host_busy, host_done, host_rdata, host_err}, 32'd0);
    checkOutput({tag, " temp outs"}, {15'd0, temp, temp_valid}, 32'd0);
  endtask

  initial begin
    int w;
    int c0;
    int starts;

    rst_n      = 1'b0;
    host_req   = 1'b0;
    host_rw    = 1'b0;
    host_reg   = 8'h00;
    host_wdata = 8'h00;
    host_len   = 2'd0;
    poll_en    = 1'b0;
    m_done     = 1'b0;
    m_ack_err  = 1'b0;
    m_rdata    = 16'h0000;

    tick();
    tick();
    checkAllZero("reset");
    rst_n = 1'b1;
    tick();

    // Host read of reg 0x0B, one byte.
    applyStimulus(1'b1, 8'h0B, 8'h00, 2'd1, 2'd1);
    tick();
    checkOutput("t1 busy after edge", {31'd0, host_busy}, 32'd1);
    checkOutput("t1 state at N", {24'd0, state}, 32'd0);
    tick();
    checkOutput("t1 state ARB", {24'd0, state}, 32'd1);
    checkOutput("t1 no early start", {31'd0, m_start}, 32'd0);
    tick();
    checkOutput("t1 m_start at N+2", {31'd0, m_start}, 32'd1);
    checkCommand("t1");
    host_req = 1'b0;
    tick();
    checkOutput("t1 WAIT", {24'd0, state}, 32'd3);
    checkOutput("t1 start one cycle", {31'd0, m_start}, 32'd0);
    respond(16'h00CB, 1'b0);
    checkOutput("t1 DONE", {24'd0, state}, 32'd4);
    checkOutput("t1 host_done", {31'd0, host_done}, 32'd1);
    checkOutput("t1 host_rdata", {16'd0, host_rdata}, 32'h00CB);
    checkOutput("t1 host_err", {31'd0, host_err}, 32'd0);
    tick();
    checkOutput("t1 back IDLE", {24'd0, state}, 32'd0);
    checkOutput("t1 done one cycle", {31'd0, host_done}, 32'd0);
    checkOutput("t1 not busy", {31'd0, host_busy}, 32'd0);

    // m_done while idle must be ignored.
    m_rdata = 16'hFFFF;
    m_done  = 1'b1;
    tick();
    m_done  = 1'b0;
    checkOutput("t2 stray done state", {24'd0, state}, 32'd0);
    checkOutput("t2 stray done rdata", {16'd0, host_rdata}, 32'h00CB);

    // Host write, len 0 collapses to one byte; second edge while busy ignored.
    applyStimulus(1'b0, 8'h03, 8'h55, 2'd0, 2'd1);
    waitStart("t3", 6, w);
    checkOutput("t3 start latency", w, 32'd3);
    checkCommand("t3");
    host_req = 1'b0;
    tick();
    host_req = 1'b1;
    host_reg = 8'h07;
    tick();
    host_req = 1'b0;
    tick();
    checkOutput("t3 busy edge no state change", {24'd0, state}, 32'd3);
    checkOutput("t3 m_reg held", {24'd0, m_reg}, 32'h03);
    respond(16'hBEEF, 1'b0);
    checkOutput("t3 write keeps rdata", {16'd0, host_rdata}, 32'h00CB);
    checkOutput("t3 host_done", {31'd0, host_done}, 32'd1);
    tick();
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_start === 1'b1) starts++;
    end
    checkOutput("t3 ignored edge no command", starts, 32'd0);
    checkOutput("t3 idle not busy", {31'd0, host_busy}, 32'd0);

    // Timeout: no m_done, abort at S+TIMEOUT+1.
    applyStimulus(1'b1, 8'h01, 8'h00, 2'd2, 2'd2);
    waitStart("t4", 6, w);
    checkCommand("t4");
    host_req = 1'b0;
    repeat (TIMEOUT) tick();
    checkOutput("t4 still WAIT at S+50", {24'd0, state}, 32'd3);
    checkOutput("t4 no early abort", {31'd0, m_abort}, 32'd0);
    tick();
    checkOutput("t4 m_abort at S+51", {31'd0, m_abort}, 32'd1);
    checkOutput("t4 ERR", {24'd0, state}, 32'd5);
    checkOutput("t4 host_done", {31'd0, host_done}, 32'd1);
    checkOutput("t4 host_err", {31'd0, host_err}, 32'd1);
    tick();
    checkOutput("t4 back IDLE", {24'd0, state}, 32'd0);
    checkOutput("t4 abort one cycle", {31'd0, m_abort}, 32'd0);
    checkOutput("t4 err sticky", {31'd0, host_err}, 32'd1);

    // New capture clears host_err; m_done on the timeout cycle wins.
    applyStimulus(1'b1, 8'h0B, 8'h00, 2'd1, 2'd1);
    tick();
    checkOutput("t5 err cleared on capture", {31'd0, host_err}, 32'd0);
    waitStart("t5", 6, w);
    checkCommand("t5");
    host_req = 1'b0;
    repeat (TIMEOUT) tick();
    respond(16'h1234, 1'b0);
    checkOutput("t5 done beats timeout", {24'd0, state}, 32'd4);
    checkOutput("t5 no abort", {31'd0, m_abort}, 32'd0);
    checkOutput("t5 rdata", {16'd0, host_rdata}, 32'h1234);
    checkOutput("t5 no err", {31'd0, host_err}, 32'd0);
    tick();

`ifdef I2C_TXN_SCHED_AUTOPOLL_EN
    // Periodic poll, 100-cycle period.
    poll_en = 1'b1;
    c0 = cyc;
    pushPoll();
    waitStart("p1", 120, w);
    checkOutput("p1 first poll time", cyc - c0, 32'd102);
    checkCommand("p1");
    tick();
    checkOutput("p1 poll not host busy", {31'd0, host_busy}, 32'd0);
    respond(16'h0C80, 1'b0);
    checkOutput("p1 temp", {16'd0, temp}, 32'h0C80);
    checkOutput("p1 temp_valid", {31'd0, temp_valid}, 32'd1);
    checkOutput("p1 no host_done", {31'd0, host_done}, 32'd0);
    tick();

    // Second poll NACKed: temp kept, marked invalid.
    pushPoll();
    waitStart("p2", 120, w);
    checkOutput("p2 period", cyc - c0, 32'd202);
    checkCommand("p2");
    tick();
    respond(16'h1234, 1'b1);
    checkOutput("p2 temp kept", {16'd0, temp}, 32'h0C80);
    checkOutput("p2 temp_valid cleared", {31'd0, temp_valid}, 32'd0);
    tick();

    // Host edge on the same cycle as the poll wrap: host first, then poll.
    while (cyc < c0 + 299) tick();
    applyStimulus(1'b1, 8'h02, 8'h00, 2'd2, 2'd2);
    pushPoll();
    waitStart("p3 host", 10, w);
    checkOutput("p3 host start time", cyc - c0, 32'd302);
    checkCommand("p3 host");
    host_req = 1'b0;
    tick();
    respond(16'hA5A5, 1'b0);
    checkOutput("p3 host rdata", {16'd0, host_rdata}, 32'hA5A5);
    checkOutput("p3 host_done", {31'd0, host_done}, 32'd1);
    waitStart("p3 poll", 10, w);
    checkOutput("p3 poll follows DONE", w, 32'd3);
    checkCommand("p3 poll");
    tick();
    respond(16'h0C90, 1'b0);
    checkOutput("p3 temp", {16'd0, temp}, 32'h0C90);
    checkOutput("p3 temp_valid", {31'd0, temp_valid}, 32'd1);
    tick();
    poll_en = 1'b0;
`else
    // Without the poll option poll_en has no effect.
    poll_en = 1'b1;
    starts = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (m_start === 1'b1) starts++;
    end
    checkOutput("np no poll command", starts, 32'd0);
    checkOutput("np temp tied", {15'd0, temp, temp_valid}, 32'd0);
    poll_en = 1'b0;
`endif

    // Asynchronous reset in the middle of WAIT.
    applyStimulus(1'b1, 8'h0B, 8'h00, 2'd1, 2'd1);
    waitStart("r1", 6, w);
    checkCommand("r1");
    host_req = 1'b0;
    tick();
    checkOutput("r1 in WAIT", {24'd0, state}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("r1 async reset");
    @(posedge FSM_Clk);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("r1 idle after reset", {24'd0, state}, 32'd0);
    checkOutput("r1 no abort after reset", {31'd0, m_abort}, 32'd0);

    checkOutput("scoreboard drained", cmd_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_txn_sched.md
# i2c_txn_sched

Transaction scheduler sitting between the Opal Kelly host wire-in/wire-out logic and the byte-level I2C master that drives the ADT7420 on I2C_SCL_1/I2C_SDA_1. Shares the single I2C master between host-initiated register accesses and an autonomous periodic temperature poll. Sequences each transaction, enforces a completion timeout, and latches results for host readback and ILA probing.

## Interface
- POLL_PERIOD, 1_000_000: FSM_Clk cycles between auto-poll requests.
- TIMEOUT, 100_000: maximum cycles from m_start to m_done before abort.
- DEV_ADDR, 7'h48: ADT7420 7-bit address (A0=A1=0).

- FSM_Clk  in  1  scheduler clock; all logic single-clock.
- rst_n  in  1  asynchronous active-low reset.
- host_req  in  1  host trigger (wire-in bit 0); rising edge requests a transaction.
- host_rw  in  1  1=read, 0=write.
- host_reg  in  8  ADT7420 register pointer.
- host_wdata  in  8  write byte.
- host_len  in  2  byte count; 2 = two bytes, any other value = one byte.
- host_busy  out  1  host transaction pending or in flight.
- host_done  out  1  one-cycle pulse on host transaction completion.
- host_rdata  out  16  last host read data, MSB first byte.
- host_err  out  1  sticky: last host transaction NACKed or timed out.
- poll_en  in  1  enables the auto-poll timer.
- temp  out  16  last good temperature register value (reg 8'h00, 2 bytes).
- temp_valid  out  1  temp holds a result from the most recent poll.
- m_start  out  1  one-cycle command strobe to I2C master.
- m_rw, m_addr[6:0], m_reg[7:0], m_wdata[7:0], m_len[1:0]  out  command fields, stable from m_start until m_done/m_abort.
- m_abort  out  1  one-cycle pulse forcing master to STOP and idle.
- m_done  in  1  master completion pulse.
- m_ack_err  in  1  valid with m_done; 1 = NACK received.
- m_rdata  in  16  valid with m_done.
- state  out  8  current state encoding, for ILA probe0.

## Operation
- States (encoding): IDLE=0, ARB=1, ISSUE=2, WAIT=3, DONE=4, ERR=5.
- IDLE: host_pend or poll_pend set -> ARB.
- ARB: host_pend wins over poll_pend; selected request fields loaded into m_* registers; owner flag recorded -> ISSUE.
- ISSUE: m_start=1 for exactly one cycle; timeout counter cleared -> WAIT.
- WAIT: m_done -> DONE; counter reaching TIMEOUT-1 without m_done -> ERR.
- DONE: host owner: host_rdata<=m_rdata (read only), host_err<=m_ack_err, host_done pulse, host_pend cleared. Poll owner: no NACK -> temp<=m_rdata, temp_valid<=1; NACK -> temp unchanged, temp_valid<=0; poll_pend cleared. -> IDLE.
- ERR: m_abort pulse; host owner: host_err<=1, host_done pulse; poll owner: temp_valid<=0; pending flag cleared -> IDLE.
- Host request: edge detect on registered host_req; fields captured at the edge. Edge while host_busy ignored, no state change.
- host_err cleared when a new host request is captured.
- Poll: counter 0..POLL_PERIOD-1 runs only while poll_en; at wrap sets poll_pend (coalesces if already set). poll_en low holds counter at 0; an existing poll_pend is still serviced. Poll command: read, DEV_ADDR, reg 8'h00, len 2.
- host_busy = host_pend or (owner=host and state != IDLE).

## Timing
- Reset: all outputs 0, state=IDLE, counters 0, pending flags 0; temp=16'h0000, temp_valid=0.
- host_req low->high sampled at edge N: ARB at N+1, m_start at N+2 (idle bus).
- m_done at cycle M: host_done/results at M+1 (DONE), IDLE at M+2.
- Timeout: m_start at S, no m_done -> m_abort at S+TIMEOUT+1.
- m_done and timeout on same cycle: m_done wins.
- Host edge and poll wrap same cycle: host served first, poll next; poll never dropped.
- m_done outside WAIT ignored.
- Asynchronous reset mid-transaction: immediate IDLE, no m_abort issued; master is reset by same rst_n.

## Configuration
- I2C_TXN_SCHED_AUTOPOLL_EN defined: poll timer, poll_pend, temp/temp_valid logic compiled in.
- Undefined: no poll timer, poll_en ignored, temp and temp_valid tied 0; scheduler serves host only.

## Structure
- Package i2c_txn_sched_pkg: state encoding constants, ADT7420_ADDR 7'h48, ADT7420_TEMP_REG 8'h00, LEN_1/LEN_2 encodings, owner codes.
- Sub-module i2c_poll_timer: counter plus poll_pend set/clear, instantiated only under I2C_TXN_SCHED_AUTOPOLL_EN.

## Test plan
- Host read reg 8'h0B len 1, master returns 16'h00CB no NACK -> m_start 2 cycles after edge with m_reg=8'h0B, host_rdata=16'h00CB, host_err=0, one host_done pulse.
- POLL_PERIOD=100, poll_en=1, master returns 16'h0C80 -> read of reg 8'h00 len 2 every 100 cycles, temp=16'h0C80, temp_valid=1.
- Host edge and poll wrap same cycle -> host command issued first, poll command issued immediately after its DONE; both complete.
- TIMEOUT=50, master never pulses m_done -> m_abort at S+51, host_err=1, host_done pulse, state returns to 0.
- Poll with m_ack_err=1 -> temp unchanged, temp_valid=0; second host edge during busy ignored; rst_n low mid-WAIT -> all outputs 0 asynchronously.
